// File: rtl/watch_display.sv
// Six-digit multiplexed seven-segment driver for the time-of-day counter.
// Snapshots seconds/minutes/hours once per frame and scans the BCD digits out one at a time.
module watch_display #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       colon,
    output logic       frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [5:0]    snap_s;
    logic [5:0]    snap_m;
    logic [4:0]    snap_h;

    logic          last_p0;
    logic          frame_end_p0;
    logic [5:0]    fld_p0;
    logic          dash_p0;
    logic          blank_p0;
    logic [3:0]    digit_p0;
    logic [6:0]    seg_p0;
    logic [5:0]    an_p0;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] digit_of(input logic [5:0] v, input logic tens);
        return tens ? 4'(v / 6'd10) : 4'(v % 6'd10);
    endfunction

    // Stage p0: pick the field for the current digit and encode it
    always_comb begin
        last_p0      = (presc == PRESC_MAX);
        frame_end_p0 = last_p0 && (idx == 3'd5);
        fld_p0       = snap_s;
        dash_p0      = (snap_s > 6'd59);
        case (idx)
            3'd2, 3'd3: begin
                fld_p0  = snap_m;
                dash_p0 = (snap_m > 6'd59);
            end
            3'd4, 3'd5: begin
                fld_p0  = {1'b0, snap_h};
                dash_p0 = (snap_h > 5'd23);
            end
            default: begin
                fld_p0  = snap_s;
                dash_p0 = (snap_s > 6'd59);
            end
        endcase
        digit_p0 = digit_of(fld_p0, idx[0]);
        // Dash is checked first, so an out-of-range hour is never blanked
        blank_p0 = BLANK_LZ && (idx == 3'd5) && (snap_h < 5'd10);
        if (dash_p0)
            seg_p0 = 7'h40;
        else if (blank_p0)
            seg_p0 = 7'h00;
        else
            seg_p0 = seg_of(digit_p0);
        an_p0 = 6'd1 << idx;
    end

    // Stage p1: scan counters, frame snapshot and registered display outputs
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            presc      <= '0;
            idx        <= 3'd0;
            snap_s     <= 6'd0;
            snap_m     <= 6'd0;
            snap_h     <= 5'd0;
            seg        <= 7'h00;
            an         <= 6'b000000;
            colon      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            presc <= last_p0 ? '0 : presc + 1'b1;
            if (last_p0)
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            if (frame_end_p0) begin
                snap_s <= seconds;
                snap_m <= minutes;
                snap_h <= hours;
            end
            frame_tick <= frame_end_p0;
            seg        <= seg_p0;
            an         <= an_p0;
            colon      <= ~snap_s[0];
        end
    end

endmodule
